pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor.sv | 125 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes PLL LOCK, debounces it into sys_resetn and re-arms the PLL on timeout.
// Optional macro LOSS_COUNT_EN: when defined, loss_count counts loss-of-lock events (saturating); otherwise tied to 0.
`timescale 1ns/1ps
module pll_lock_supervisor #(
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 2500000,
  parameter int RST_PULSE     = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clk_25MHz,
  input  logic             resetn,
  input  logic             locked_async,
  output logic             pll_rst,
  output logic             sys_resetn,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count,
  output logic [1:0]       state_o
);

  localparam int T_MAX_A = (STABLE_CYCLES > LOCK_TIMEOUT) ? STABLE_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX   = (T_MAX_A > RST_PULSE) ? T_MAX_A : RST_PULSE;
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(RST_PULSE - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    PLL_RESET = 2'd3
  } state_t;

  state_t             state;
  logic               sync1;
  logic               locked_s;
  logic [TIMER_W-1:0] timer;

`ifdef LOSS_COUNT_EN
  logic [CNT_W-1:0] loss_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign loss_count = loss_cnt;
`else
  assign loss_count = '0;
`endif

  assign state_o = state;

  always_ff @(posedge clk_25MHz) begin
    if (!resetn) begin
      state      <= WAIT_LOCK;
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      timer      <= '0;
      pll_rst    <= 1'b0;
      sys_resetn <= 1'b0;
      lock_lost  <= 1'b0;
`ifdef LOSS_COUNT_EN
      loss_cnt   <= '0;
`endif
    end else begin
      // Two-flop synchronizer; the FSM below only ever looks at locked_s.
      sync1     <= locked_async;
      locked_s  <= sync1;
      lock_lost <= 1'b0;
      case (state)
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABILIZE;
            timer <= '0;
          end else if (timer == TIMEOUT_LAST) begin
            state   <= PLL_RESET;
            pll_rst <= 1'b1;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == STABLE_LAST) begin
            state      <= RUN;
            sys_resetn <= 1'b1;
            timer      <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            sys_resetn <= 1'b0;
            lock_lost  <= 1'b1;
            timer      <= '0;
`ifdef LOSS_COUNT_EN
            loss_cnt   <= sat_inc(loss_cnt);
`endif
          end
        end
        PLL_RESET: begin
          // Lock is deliberately ignored while the PLL is held in reset.
          if (timer == PULSE_LAST) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: time-stamped reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam int SC = 8;
  localparam int LT = 20;
  localparam int RP = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          resetn = 1'b0;
  logic          locked_async = 1'b0;
  logic          pll_rst;
  logic          sys_resetn;
  logic          lock_lost;
  logic [CW-1:0] loss_count;
  logic [1:0]    state_o;

  int n_chk  = 0;
  int n_pass = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES(SC),
    .LOCK_TIMEOUT (LT),
    .RST_PULSE    (RP),
    .CNT_W        (CW)
  ) dut (
    .clk_25MHz   (clk),
    .resetn      (resetn),
    .locked_async(locked_async),
    .pll_rst     (pll_rst),
    .sys_resetn  (sys_resetn),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int exp_loss(input int n);
`ifdef LOSS_COUNT_EN
    return (n > CMAX) ? CMAX : n;
`else
    return 0 * n;
`endif
  endfunction

  // Reference model: per-edge history of sampled lock, phase identified by
  // its entry edge; elapsed edges since entry decide the timed transitions.
  int samp [0:4095];
  bit rsted[0:4095];
  int e = 0;
  int m_st = 0;
  int m_enter = 0;
  int m_loss = 0;
  int m_ll = 0;
  int ls, el;
  bit mvalid = 0;

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("cmp_state",      int'(state_o),    m_st);
      chk("cmp_pll_rst",    int'(pll_rst),    int'(m_st == 3));
      chk("cmp_sys_resetn", int'(sys_resetn), int'(m_st == 2));
      chk("cmp_lock_lost",  int'(lock_lost),  m_ll);
      chk("cmp_loss_count", int'(loss_count), exp_loss(m_loss));
    end
    if (e > 4095) begin
      $display("FAIL model_history: edge %0d exceeds limit 4095", e);
      $fatal(1);
    end
    if (!resetn) begin
      rsted[e] = 1'b1;
      samp[e]  = 0;
      m_st     = 0;
      m_enter  = e;
      m_ll     = 0;
      m_loss   = 0;
    end else begin
      rsted[e] = 1'b0;
      samp[e]  = int'(locked_async);
      ls = 0;
      if (e >= 2) ls = rsted[e-1] ? 0 : samp[e-2];
      el   = e - m_enter;
      m_ll = 0;
      case (m_st)
        0: if (ls != 0) begin m_st = 1; m_enter = e; end
           else if (el == LT) begin m_st = 3; m_enter = e; end
        1: if (ls == 0) begin m_st = 0; m_enter = e; end
           else if (el == SC) begin m_st = 2; m_enter = e; end
        2: if (ls == 0) begin m_st = 0; m_enter = e; m_ll = 1; m_loss++; end
        default: if (el == RP) begin m_st = 0; m_enter = e; end
      endcase
    end
    e++;
    mvalid = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    locked_async = 1'b0;
    tick(3);
    chk("rst_state",      int'(state_o),    0);
    chk("rst_sys_resetn", int'(sys_resetn), 0);
    chk("rst_pll_rst",    int'(pll_rst),    0);
    chk("rst_lock_lost",  int'(lock_lost),  0);
    chk("rst_loss_count", int'(loss_count), 0);

    // Normal lock: sample edge A -> STABILIZE at A+2 -> RUN at A+10
    resetn = 1'b1;
    locked_async = 1'b1;
    tick(2);
    chk("lock_state_a1", int'(state_o), 0);
    tick(1);
    chk("lock_state_a2", int'(state_o), 1);
    tick(7);
    chk("lock_sys_a9", int'(sys_resetn), 0);
    tick(1);
    chk("lock_sys_a10",   int'(sys_resetn), 1);
    chk("lock_state_a10", int'(state_o),    2);
    chk("lock_pll_a10",   int'(pll_rst),    0);

    // Four losses of lock with relock in between
    for (int i = 0; i < 4; i++) begin
      locked_async = 1'b0;
      tick(2);
      chk("loss_sys_a1", int'(sys_resetn), 1);
      chk("loss_ll_a1",  int'(lock_lost),  0);
      tick(1);
      chk("loss_sys_a2",   int'(sys_resetn), 0);
      chk("loss_ll_a2",    int'(lock_lost),  1);
      chk("loss_state_a2", int'(state_o),    0);
      chk("loss_count_a2", int'(loss_count), exp_loss(i + 1));
      tick(1);
      chk("loss_ll_a3", int'(lock_lost), 0);
      locked_async = 1'b1;
      tick(11);
      chk("relock_sys", int'(sys_resetn), 1);
    end

    // Fifth loss: counter stays saturated
    locked_async = 1'b0;
    tick(4);
    chk("loss5_count", int'(loss_count), exp_loss(5));
    chk("loss5_state", int'(state_o),    0);

    // Glitch during STABILIZE: 4 high, 1 low, high again
    locked_async = 1'b1;
    tick(4);
    locked_async = 1'b0;
    tick(1);
    locked_async = 1'b1;
    tick(2);
    chk("glitch_state_back", int'(state_o),    0);
    chk("glitch_no_ll",      int'(lock_lost),  0);
    chk("glitch_sys_low",    int'(sys_resetn), 0);
    tick(1);
    chk("glitch_restab", int'(state_o), 1);
    tick(7);
    chk("glitch_sys_g14", int'(sys_resetn), 0);
    tick(1);
    chk("glitch_sys_g15", int'(sys_resetn), 1);

    // Timeout: lock held low after reset release
    resetn = 1'b0;
    locked_async = 1'b0;
    tick(2);
    chk("rst2_loss_count", int'(loss_count), 0);
    resetn = 1'b1;
    tick(19);
    chk("to_pll_a18", int'(pll_rst), 0);
    tick(1);
    chk("to_pll_a19",   int'(pll_rst), 1);
    chk("to_state_a19", int'(state_o), 3);
    tick(3);
    chk("to_pll_a22", int'(pll_rst), 1);
    tick(1);
    chk("to_pll_a23",   int'(pll_rst), 0);
    chk("to_state_a23", int'(state_o), 0);
    tick(19);
    chk("to2_pll_a42", int'(pll_rst), 0);
    tick(1);
    chk("to2_pll_a43", int'(pll_rst), 1);
    tick(1);
    chk("to2_pll_a44", int'(pll_rst), 1);

    // Reset during the second cycle of the pulse truncates it
    resetn = 1'b0;
    tick(1);
    chk("midrst_pll",   int'(pll_rst),    0);
    chk("midrst_state", int'(state_o),    0);
    chk("midrst_sys",   int'(sys_resetn), 0);
    chk("midrst_loss",  int'(loss_count), 0);

    // Precedence: lock seen on the timeout cycle wins
    resetn = 1'b1;
    tick(17);
    locked_async = 1'b1;
    tick(2);
    chk("prec_state_a18", int'(state_o), 0);
    chk("prec_pll_a18",   int'(pll_rst), 0);
    tick(1);
    chk("prec_state_a19", int'(state_o), 1);
    chk("prec_pll_a19",   int'(pll_rst), 0);
    tick(3);
    chk("prec_pll_after", int'(pll_rst), 0);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
